// File: rtl/muldiv_pkg.sv
// Shared opcode/state encodings and fixed latencies for the HI/LO multiply-divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Cycles busy is held for a div/divu: 32 iterations plus one sign-fix cycle.
  localparam int DIV_LAT = 33;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core, one quotient bit per step, MSB first; DIV_ITERS steps after load.
// No backpressure: the owner asserts step_i each cycle and watches last_o for the final step.
module div_iter #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        last_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [32:0] trial;
  logic [31:0] diff;
  logic        ge;

  // The quotient register doubles as the dividend shifter, feeding its MSB into the remainder.
  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial[31:0] - dvs_q;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      rem_d = ge ? diff : trial[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o      = step_i && (cnt_q == CW'(DIV_ITERS - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO multiply-divide unit: mult/multu write HI/LO MUL_LAT cycles after accept, div/divu after 33.
// While busy is high every request is dropped; the pipeline must stall and re-present it.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  muldiv_op_t  op_e;
  logic        div_load;
  logic        div_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] ext_a, ext_b, prod;
  logic        iter_last;
  logic [31:0] quo_w, rem_w;

  assign op_e       = muldiv_op_t'(op);
  assign div_signed = (op_e == OP_DIV);
  assign abs_a      = (div_signed && a[31]) ? -a : a;
  assign abs_b      = (div_signed && b[31]) ? -b : b;

  // Sign-extending only for mult lets one 64-bit multiplier serve both signednesses.
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  div_iter #(.DIV_ITERS(32)) u_div_iter (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (div_load),
    .step_i      (state_q == DIV),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .last_o      (iter_last),
    .quotient_o  (quo_w),
    .remainder_o (rem_w)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              state_d = MUL;
              cnt_d   = '0;
              a_d     = a;
              b_d     = b;
              sgn_d   = (op_e == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d  = DIV;
              div_load = 1'b1;
              a_d      = a;
              b_d      = b;
              qneg_d   = div_signed & (a[31] ^ b[31]);
              rneg_d   = div_signed & a[31];
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end
      end
      DIV: begin
        if (iter_last) state_d = FIX;
      end
      FIX: begin
        if (b_q == '0) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = qneg_q ? -quo_w : quo_w;
          hi_d = rneg_q ? -rem_w : rem_w;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomised self-checking bench for muldiv_hilo against an arithmetic reference model.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int TB_MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_hilo #(.MUL_LAT(TB_MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // {hi, lo} of the full 64-bit product.
  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    if (o == OP_MULT) begin
      sx = $signed(x);
      sy = $signed(y);
      return 64'(sx * sy);
    end
    ux = x;
    uy = y;
    return ux * uy;
  endfunction

  // {hi=remainder, lo=quotient}; 64-bit arithmetic makes the -2^31/-1 case fall out naturally.
  function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == OP_DIV) begin
      sx = $signed(x);
      sy = $signed(y);
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    ux = x;
    uy = y;
    uq = ux / uy;
    ur = ux % uy;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with operands scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts busy cycles; returns at the first negedge where busy is low.
  task automatic wait_idle(output int lat, output bit early, output bit tmo);
    lat   = 0;
    early = 1'b0;
    tmo   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
      lat++;
      if (done) early = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = OP_NONE;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    hi_m = '0;
    lo_m = '0;
  endtask

  task automatic test_mul;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp;
    int lat;
    bit early, tmo;
    for (int n = 0; n < 18; n++) begin
      if (n == 0) begin o = OP_MULTU; x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
      else if (n == 1) begin o = OP_MULT; x = 32'hFFFF_FFFD; y = 32'd5; end
      else begin
        o = (n % 2 == 0) ? OP_MULT : OP_MULTU;
        x = $urandom;
        y = (n % 3 == 0) ? $urandom_range(0, 15) : $urandom;
      end
      exp = ref_mul(o, x, y);
      issue(o, x, y);
      wait_idle(lat, early, tmo);
      total++; if (tmo) begin bad++; $display("FAIL mul_timeout n=%0d busy never dropped", n); end
      total++; if (lat != TB_MUL_LAT) begin bad++; $display("FAIL mul_latency n=%0d got=%0d want=%0d", n, lat, TB_MUL_LAT); end
      total++; if (early) begin bad++; $display("FAIL mul_done_early n=%0d got=1 want=0", n); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL mul_done n=%0d got=%b want=1", n, done); end
      total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL mul_result n=%0d op=%0d a=%h b=%h got=%h_%h want=%h", n, o, x, y, hi, lo, exp); end
      {hi_m, lo_m} = exp;
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse n=%0d got=%b want=0", n, done); end
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] v;
    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    total++; if (hi !== hi_m) begin bad++; $display("FAIL mthi_no_bypass got=%h want=%h", hi, hi_m); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    hi_m = 32'h1234_5678;
    total++; if (hi !== hi_m) begin bad++; $display("FAIL mthi_hi got=%h want=%h", hi, hi_m); end
    total++; if (lo !== lo_m) begin bad++; $display("FAIL mthi_lo got=%h want=%h", lo, lo_m); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mthi_done got=%b want=0", done); end
    v = $urandom;
    issue(OP_MTLO, v, $urandom);
    lo_m = v;
    total++; if (lo !== lo_m) begin bad++; $display("FAIL mtlo_lo got=%h want=%h", lo, lo_m); end
    total++; if (hi !== hi_m) begin bad++; $display("FAIL mtlo_hi got=%h want=%h", hi, hi_m); end
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 3'b000 : 3'b111, $urandom, $urandom);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL noop_busy k=%0d got=%b want=0", k, busy); end
      total++; if ({hi, lo} !== {hi_m, lo_m}) begin bad++; $display("FAIL noop_hilo k=%0d got=%h_%h want=%h_%h", k, hi, lo, hi_m, lo_m); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp;
    int lat;
    bit early, tmo;
    for (int n = 0; n < 16; n++) begin
      case (n)
        0: begin o = OP_DIV;  x = 32'hFFFF_FFF9; y = 32'd2; end
        1: begin o = OP_DIVU; x = 32'hFFFF_FFF9; y = 32'd2; end
        2: begin o = OP_DIV;  x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: begin o = OP_DIVU; x = 32'h0000_0055; y = 32'd0; end
        4: begin o = OP_DIV;  x = 32'h8000_0007; y = 32'd0; end
        default: begin
          o = (n % 2 == 0) ? OP_DIV : OP_DIVU;
          x = $urandom;
          y = (n % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
          if (n % 4 == 1) y = -y;
        end
      endcase
      exp = ref_div(o, x, y);
      issue(o, x, y);
      wait_idle(lat, early, tmo);
      total++; if (tmo) begin bad++; $display("FAIL div_timeout n=%0d busy never dropped", n); end
      total++; if (lat != DIV_LAT) begin bad++; $display("FAIL div_latency n=%0d got=%0d want=%0d", n, lat, DIV_LAT); end
      total++; if (early) begin bad++; $display("FAIL div_done_early n=%0d got=1 want=0", n); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL div_done n=%0d got=%b want=1", n, done); end
      total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL div_result n=%0d op=%0d a=%h b=%h got=%h_%h want=%h", n, o, x, y, hi, lo, exp); end
      {hi_m, lo_m} = exp;
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL div_done_pulse n=%0d got=%b want=0", n, done); end
    end
  endtask

  task automatic test_ignore_busy;
    int lat;
    bit early, tmo;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
    repeat (3) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
    end
    start = 1'b0; op = OP_NONE;
    wait_idle(lat, early, tmo);
    lat += 7;
    total++; if (tmo) begin bad++; $display("FAIL ignore_timeout busy never dropped"); end
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, DIV_LAT); end
    total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL ignore_result got=%h_%h want=00000002_0000000e", hi, lo); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_done got=%b want=1", done); end
    hi_m = 32'd2; lo_m = 32'd14;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_replay got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses;
    bit early, tmo;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL midreset_hilo got=%h_%h want=0", hi, lo); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy || hi != 0 || lo != 0) pulses++;
      @(negedge clk);
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midreset_quiet got=%0d want=0 active cycles", pulses); end
    issue(OP_MULT, 32'd6, 32'd7);
    wait_idle(lat, early, tmo);
    total++; if (lat != TB_MUL_LAT || tmo) begin bad++; $display("FAIL midreset_mul_latency got=%0d want=%0d", lat, TB_MUL_LAT); end
    total++; if ({hi, lo} !== {32'd0, 32'd42}) begin bad++; $display("FAIL midreset_mul got=%h_%h want=00000000_0000002a", hi, lo); end
    hi_m = 32'd0; lo_m = 32'd42;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  o;
    logic [31:0] x, y;
    int lat;
    bit early, tmo;
    for (int n = 0; n < 24; n++) begin
      o = 3'($urandom_range(1, 6));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      issue(o, x, y);
      if (o == OP_MTHI) hi_m = x;
      else if (o == OP_MTLO) lo_m = x;
      else begin
        wait_idle(lat, early, tmo);
        if (o == OP_MULT || o == OP_MULTU) {hi_m, lo_m} = ref_mul(o, x, y);
        else {hi_m, lo_m} = ref_div(o, x, y);
        total++; if (tmo || early || done !== 1'b1) begin bad++; $display("FAIL b2b_handshake n=%0d tmo=%0d early=%0d done=%b", n, tmo, early, done); end
      end
      total++; if ({hi, lo} !== {hi_m, lo_m}) begin bad++; $display("FAIL b2b_result n=%0d op=%0d a=%h b=%h got=%h_%h want=%h_%h", n, o, x, y, hi, lo, hi_m, lo_m); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = OP_NONE;
    a     = '0;
    b     = '0;
    @(negedge clk);
    test_reset;
    test_mul;
    test_mthi_mtlo;
    test_div;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the execute stage beside the ALU.
- Executes MIPS mult, multu, div, divu, mthi and mtlo, and holds HI/LO for mfhi/mflo.
- Raises `busy` so the hazard unit stalls the pipeline while an operation is in flight.
- Replaces the combinational 64-bit product/quotient path in the ALU.

Parameters:
- MUL_LAT, 4, cycles from accepted mult/multu to HI/LO write; legal range 1..8.
- DIV_ITERS, 32, restoring-division iterations; fixed at 32, parameterised only for the sub-module.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operation request from the execute stage.
- op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 reserved, treated as none.
- a  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- b  input  32  rt operand (divisor / multiplier).
- busy  output  1  operation in flight; new requests are ignored.
- done  output  1  one-cycle pulse on the edge HI/LO are written by mult/div.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. An in-flight operation is aborted and no result is written.
- Accept: at edge E0 with start=1, busy=0, op valid.
- mthi/mtlo: hi (or lo) <= a at E0. busy stays 0 and done stays 0. The new value is visible on the hi/lo outputs the cycle after E0; there is no bypass.
- Requests while busy=1: ignored completely. The pipeline must hold the instruction; it is re-presented when busy drops.
- op=none or op=111 with start=1: no effect.
- FSM states: IDLE, MUL, DIV, FIX.
- mult/multu path:
  - IDLE->MUL at E0; operands latched; busy=1 from the cycle after E0.
  - Counter counts MUL_LAT edges. At edge E_MUL_LAT: {hi,lo} <= 64-bit product, done=1, state->IDLE, busy=0.
  - mult is signed 32x32; multu is unsigned. The full 64 bits are kept, with no truncation.
- div/divu path:
  - IDLE->DIV at E0; operands latched.
  - Signed div takes absolute values and records the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
  - Edges E1..E32: one restoring iteration each, MSB first.
  - DIV->FIX after E32.
  - Edge E33: sign correction; lo <= quotient, hi <= remainder, done=1, state->IDLE.
  - busy=1 for exactly 33 cycles.
- Signed division rules: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no trap.
- Divide by zero (div or divu): full 33-cycle latency is kept. Result is lo=0xFFFFFFFF, hi=a (latched dividend), independent of signedness.
- Operands are latched at E0, so changes on a/b during busy have no effect.
- hi/lo change only on reset, mthi/mtlo, or mult/div completion.
- done is low in every cycle except the completion cycle.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic [2:0] muldiv_op_t (OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO).
  - typedef enum state_t (IDLE, MUL, DIV, FIX).
  - Localparam DIV_LAT=33.
- Sub-module div_iter: unsigned 32/32 restoring divider core. It has one-bit-per-cycle step logic, an iteration counter, and quotient/remainder outputs. muldiv_hilo owns sign handling, the divide-by-zero override and the FSM.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> after MUL_LAT=4 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulses 1 cycle, busy high exactly 4 cycles.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then mthi a=0x12345678 -> hi=0x12345678 next cycle, lo unchanged, busy stays 0.
- div a=0xFFFFFFF9 (-7) b=2 -> at E33: lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu same operands -> lo=0x7FFFFFFC, hi=0x00000001; busy high 33 cycles each.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; divu a=0x55 b=0 -> lo=0xFFFFFFFF, hi=0x55 after 33 cycles.
- Start divu 100/7, then at cycle 5 drive start=1 op=mult a=2 b=3 and change a/b -> mult ignored; result lo=14, hi=2 at E33.
- Start div 100/7, assert reset at cycle 10 -> next cycle: busy=0, hi=0, lo=0, no done pulse; then mult 6x7 completes normally: lo=42, hi=0.
